// File: rtl/voter_pkg.sv
// Shared types and helpers for the N-modular-redundancy voter.
package voter_pkg;

  typedef enum logic [1:0] {
    CH_OK      = 2'd0,
    CH_SUSPECT = 2'd1,
    CH_FAULT   = 2'd2
  } chan_state_t;

  localparam int MAX_N = 7;

  // Number of set bits in a channel mask.
  function automatic int popcount(input logic [MAX_N-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_N; i++) c += int'(v[i]);
    return c;
  endfunction

  // Width of a miss counter that has to hold the value lim.
  function automatic int miss_w(input int lim);
    return $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/voter_chan_mon.sv
// Per-channel health monitor: consecutive-miss counter and OK/SUSPECT/FAULT FSM.
import voter_pkg::*;

module voter_chan_mon #(
  parameter int MISS_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        disagree,
  input  logic        clear,
  output logic        fault,
  output chan_state_t state
);

  localparam int MW = miss_w(MISS_LIMIT);

  chan_state_t   state_q, state_d;
  logic [MW-1:0] miss_q, miss_d;

  // State and miss counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CH_OK;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
    end
  end

  // Next state: clear beats any disagreement; only valid samples advance the FSM.
  always_comb begin
    state_d = state_q;
    miss_d  = miss_q;
    if (clear) begin
      state_d = CH_OK;
      miss_d  = '0;
    end else if (in_valid) begin
      case (state_q)
        CH_OK: begin
          if (disagree) begin
            state_d = CH_SUSPECT;
            miss_d  = MW'(1);
          end
        end
        CH_SUSPECT: begin
          if (disagree) begin
            if (int'(miss_q) + 1 >= MISS_LIMIT) begin
              // Counter saturates at the limit; the channel drops out.
              state_d = CH_FAULT;
              miss_d  = MW'(MISS_LIMIT);
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else begin
            state_d = CH_OK;
            miss_d  = '0;
          end
        end
        CH_FAULT: ;
        default: begin
          state_d = CH_OK;
          miss_d  = '0;
        end
      endcase
    end
  end

  assign fault = (state_q == CH_FAULT);
  assign state = state_q;

endmodule

// File: rtl/voter_nmr.sv
// N-channel bitwise majority voter with tie handling and per-channel exclusion.
import voter_pkg::*;

module voter_nmr #(
  parameter int WIDTH      = 8,
  parameter int N          = 3,
  parameter int MISS_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [N*WIDTH-1:0] ch_data,
  input  logic [N-1:0]       clear_fault,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               no_majority,
  output logic               all_agree,
  output logic [N-1:0]       ch_fault,
  output logic               degraded
);

  logic [N-1:0][WIDTH-1:0] ch_w;
  chan_state_t             st [N];
  logic [N-1:0]            active, disagree;
  logic [WIDTH-1:0]        decided, vote_bit, uniform;
  int                      act_cnt;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             no_maj_q, no_maj_d;
  logic             all_agree_q, all_agree_d;

  assign ch_w = ch_data;

  // Bitwise vote over the active set; a bit is decided only when it is not a tie.
  always_comb begin
    int ones;
    ones     = 0;
    act_cnt  = popcount(MAX_N'(active));
    decided  = '0;
    vote_bit = '0;
    uniform  = '0;
    for (int b = 0; b < WIDTH; b++) begin
      ones = 0;
      for (int i = 0; i < N; i++)
        if (active[i] && ch_w[i][b]) ones++;
      decided[b]  = (2 * ones != act_cnt);
      vote_bit[b] = (2 * ones > act_cnt);
      uniform[b]  = (ones == 0) || (ones == act_cnt);
    end
  end

  // Undecided bits keep their previous output value.
  always_comb begin
    out_data_d  = (vote_bit & decided) | (out_data_q & ~decided);
    no_maj_d    = ~&decided;
    all_agree_d = (act_cnt >= 1) && (&uniform);
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    assign active[i]   = (st[i] != CH_FAULT);
    assign disagree[i] = active[i] & (|((ch_w[i] ^ vote_bit) & decided));

    voter_chan_mon #(.MISS_LIMIT(MISS_LIMIT)) u_mon (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .disagree (disagree[i]),
      .clear    (clear_fault[i]),
      .fault    (ch_fault[i]),
      .state    (st[i])
    );
  end

  // Output registers: updated only on valid samples, valid strobe follows input by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      no_maj_q    <= 1'b0;
      all_agree_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        out_data_q  <= out_data_d;
        no_maj_q    <= no_maj_d;
        all_agree_q <= all_agree_d;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign no_majority = no_maj_q;
  assign all_agree   = all_agree_q;
  // OR of the registered fault flags, so it moves on the same edge as ch_fault.
  assign degraded    = |ch_fault;

endmodule

// File: tb/tb_voter_nmr.sv
// Table-driven bench for voter_nmr (N=3 and N=5 instances) with a scoreboard queue.
module tb_voter_nmr;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [39:0] d;
    logic [4:0]  clr;
    logic        e_vld;
    logic [7:0]  e_dat;
    logic        e_nm;
    logic        e_aa;
    logic [4:0]  e_flt;
  } vec_t;

  localparam logic lo = 1'b0;
  localparam logic hi = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst3 = 1'b1, vld3 = 1'b0;
  logic [23:0] d3 = '0;
  logic [2:0]  clr3 = '0;
  logic        ov3, nm3, aa3, dg3;
  logic [7:0]  od3;
  logic [2:0]  flt3;

  logic        rst5 = 1'b1, vld5 = 1'b0;
  logic [39:0] d5 = '0;
  logic [4:0]  clr5 = '0;
  logic        ov5, nm5, aa5, dg5;
  logic [7:0]  od5;
  logic [4:0]  flt5;

  voter_nmr #(.WIDTH(8), .N(3), .MISS_LIMIT(4)) dut3 (
    .clk(clk), .rst(rst3), .in_valid(vld3), .ch_data(d3), .clear_fault(clr3),
    .out_valid(ov3), .out_data(od3), .no_majority(nm3), .all_agree(aa3),
    .ch_fault(flt3), .degraded(dg3)
  );

  voter_nmr #(.WIDTH(8), .N(5), .MISS_LIMIT(4)) dut5 (
    .clk(clk), .rst(rst5), .in_valid(vld5), .ch_data(d5), .clear_fault(clr5),
    .out_valid(ov5), .out_data(od5), .no_majority(nm5), .all_agree(aa5),
    .ch_fault(flt5), .degraded(dg5)
  );

  int   checks = 0;
  int   errors = 0;
  vec_t sb[$];
  vec_t t3[$];
  vec_t t5[$];

  task automatic chk(input string nm, input int idx, input logic [39:0] a, input logic [39:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, a, e);
    end
  endtask

  function automatic vec_t mk3(input logic r, input logic v, input logic [23:0] d, input logic [2:0] c,
                               input logic ev, input logic [7:0] ed, input logic enm, input logic eaa,
                               input logic [2:0] ef);
    vec_t x;
    x.rst = r; x.vld = v; x.d = {16'h0, d}; x.clr = {2'b0, c};
    x.e_vld = ev; x.e_dat = ed; x.e_nm = enm; x.e_aa = eaa; x.e_flt = {2'b0, ef};
    return x;
  endfunction

  function automatic vec_t mk5(input logic r, input logic v, input logic [39:0] d, input logic [4:0] c,
                               input logic ev, input logic [7:0] ed, input logic enm, input logic eaa,
                               input logic [4:0] ef);
    vec_t x;
    x.rst = r; x.vld = v; x.d = d; x.clr = c;
    x.e_vld = ev; x.e_dat = ed; x.e_nm = enm; x.e_aa = eaa; x.e_flt = ef;
    return x;
  endfunction

  // Drive one record, push its expectation, compare after the edge.
  task automatic apply(input vec_t v, input bit five, input int idx);
    vec_t e;
    if (five) begin
      rst5 = v.rst; vld5 = v.vld; d5 = v.d; clr5 = v.clr;
    end else begin
      rst3 = v.rst; vld3 = v.vld; d3 = v.d[23:0]; clr3 = v.clr[2:0];
    end
    sb.push_back(v);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    if (five) begin
      rst5 = 1'b0; vld5 = 1'b0; clr5 = '0;
      chk("n5_valid", idx, 40'(ov5), 40'(e.e_vld));
      chk("n5_data", idx, 40'(od5), 40'(e.e_dat));
      chk("n5_nomaj", idx, 40'(nm5), 40'(e.e_nm));
      chk("n5_agree", idx, 40'(aa5), 40'(e.e_aa));
      chk("n5_fault", idx, 40'(flt5), 40'(e.e_flt));
      chk("n5_degraded", idx, 40'(dg5), 40'(|e.e_flt));
    end else begin
      rst3 = 1'b0; vld3 = 1'b0; clr3 = '0;
      chk("n3_valid", idx, 40'(ov3), 40'(e.e_vld));
      chk("n3_data", idx, 40'(od3), 40'(e.e_dat));
      chk("n3_nomaj", idx, 40'(nm3), 40'(e.e_nm));
      chk("n3_agree", idx, 40'(aa3), 40'(e.e_aa));
      chk("n3_fault", idx, 40'(flt3), 40'(e.e_flt[2:0]));
      chk("n3_degraded", idx, 40'(dg3), 40'(|e.e_flt));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    // ---- N=3 table: {ch2,ch1,ch0} ----
    t3.push_back(mk3(hi, lo, 24'h000000, 3'b000, lo, 8'h00, lo, lo, 3'b000)); // reset state
    t3.push_back(mk3(lo, hi, 24'hA5A5A5, 3'b000, hi, 8'hA5, lo, hi, 3'b000)); // unanimous
    t3.push_back(mk3(lo, lo, 24'h000000, 3'b000, lo, 8'hA5, lo, hi, 3'b000)); // idle holds
    for (int k = 0; k < 3; k++)
      t3.push_back(mk3(lo, hi, 24'h0F0FFF, 3'b000, hi, 8'h0F, lo, lo, 3'b000)); // ch0 miss 1..3
    t3.push_back(mk3(lo, hi, 24'h0F0F0F, 3'b000, hi, 8'h0F, lo, hi, 3'b000)); // ch0 back to OK
    for (int k = 0; k < 3; k++)
      t3.push_back(mk3(lo, hi, 24'h0F0FFF, 3'b000, hi, 8'h0F, lo, lo, 3'b000)); // recount from 0
    t3.push_back(mk3(lo, hi, 24'h0F0F0F, 3'b000, hi, 8'h0F, lo, hi, 3'b000));
    for (int k = 0; k < 3; k++)
      t3.push_back(mk3(lo, hi, 24'h003C3C, 3'b000, hi, 8'h3C, lo, lo, 3'b000)); // ch2 miss 1..3
    t3.push_back(mk3(lo, hi, 24'h003C3C, 3'b000, hi, 8'h3C, lo, lo, 3'b100)); // ch2 faults
    t3.push_back(mk3(lo, hi, 24'hFF3D3C, 3'b000, hi, 8'h3C, hi, lo, 3'b100)); // A=2 tie bit0
    t3.push_back(mk3(lo, hi, 24'h003C3C, 3'b100, hi, 8'h3C, lo, hi, 3'b000)); // clear faulted ch2
    t3.push_back(mk3(lo, hi, 24'h3C3C3C, 3'b000, hi, 8'h3C, lo, hi, 3'b000));
    for (int k = 0; k < 3; k++)
      t3.push_back(mk3(lo, hi, 24'h003C3C, 3'b000, hi, 8'h3C, lo, lo, 3'b000)); // ch2 miss 1..3
    t3.push_back(mk3(lo, hi, 24'h003C3C, 3'b100, hi, 8'h3C, lo, lo, 3'b000)); // clear beats 4th miss
    for (int k = 0; k < 3; k++)
      t3.push_back(mk3(lo, hi, 24'h003C3C, 3'b000, hi, 8'h3C, lo, lo, 3'b000)); // miss 1..3 again
    t3.push_back(mk3(lo, hi, 24'h003C3C, 3'b000, hi, 8'h3C, lo, lo, 3'b100)); // fault
    t3.push_back(mk3(lo, lo, 24'h003C3C, 3'b100, lo, 8'h3C, lo, lo, 3'b000)); // clear w/o valid
    t3.push_back(mk3(lo, hi, 24'h003C3C, 3'b000, hi, 8'h3C, lo, lo, 3'b000)); // miss 1
    t3.push_back(mk3(lo, lo, 24'h003C3C, 3'b000, lo, 8'h3C, lo, lo, 3'b000)); // idle: no count
    t3.push_back(mk3(lo, hi, 24'h003C3C, 3'b000, hi, 8'h3C, lo, lo, 3'b000)); // miss 2
    t3.push_back(mk3(lo, hi, 24'h003C3C, 3'b000, hi, 8'h3C, lo, lo, 3'b000)); // miss 3
    t3.push_back(mk3(lo, lo, 24'h003C3C, 3'b000, lo, 8'h3C, lo, lo, 3'b000)); // idle
    t3.push_back(mk3(lo, hi, 24'h003C3C, 3'b000, hi, 8'h3C, lo, lo, 3'b100)); // miss 4 -> fault
    t3.push_back(mk3(lo, hi, 24'h3C3C3C, 3'b100, hi, 8'h3C, lo, hi, 3'b000)); // re-admit
    for (int k = 0; k < 2; k++)
      t3.push_back(mk3(lo, hi, 24'h3CC33C, 3'b000, hi, 8'h3C, lo, lo, 3'b000)); // ch1 miss 1..2
    t3.push_back(mk3(hi, hi, 24'h3CC33C, 3'b000, lo, 8'h00, lo, lo, 3'b000)); // reset mid-stream
    t3.push_back(mk3(lo, hi, 24'h5AA55A, 3'b000, hi, 8'h5A, lo, lo, 3'b000)); // cold start, miss 1
    for (int k = 0; k < 2; k++)
      t3.push_back(mk3(lo, hi, 24'h5AA55A, 3'b000, hi, 8'h5A, lo, lo, 3'b000)); // miss 2..3
    t3.push_back(mk3(lo, hi, 24'h5AA55A, 3'b000, hi, 8'h5A, lo, lo, 3'b010)); // ch1 faults
    t3.push_back(mk3(lo, hi, 24'h5A5A5A, 3'b000, hi, 8'h5A, lo, hi, 3'b010)); // excluded channel

    // ---- N=5 sequence: {ch4,ch3,ch2,ch1,ch0} ----
    t5.push_back(mk5(hi, lo, 40'h0000000000, 5'b00000, lo, 8'h00, lo, lo, 5'b00000));
    t5.push_back(mk5(lo, hi, 40'h0011111111, 5'b00000, hi, 8'h11, lo, lo, 5'b00000)); // ch4 miss 1
    for (int k = 0; k < 2; k++)
      t5.push_back(mk5(lo, hi, 40'h0011111122, 5'b00000, hi, 8'h11, lo, lo, 5'b00000));
    t5.push_back(mk5(lo, hi, 40'h0011111122, 5'b00000, hi, 8'h11, lo, lo, 5'b10000)); // ch4 out, ch0 miss 3
    for (int k = 0; k < 2; k++)
      t5.push_back(mk5(lo, hi, 40'hFF0000FFFF, 5'b00000, hi, 8'h11, hi, lo, 5'b10000)); // all bits tied
    t5.push_back(mk5(lo, hi, 40'h0011111122, 5'b00000, hi, 8'h11, lo, lo, 5'b10000)); // ch0 miss 1 only

    for (int i = 0; i < t3.size(); i++) apply(t3[i], 1'b0, i);
    for (int i = 0; i < t5.size(); i++) apply(t5[i], 1'b1, i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
